pwm_channel: RTL and testbench

//  Converts the level word produced by the rotary-encoder stage into a pulse-width-modulated

---
 rtl/pwm_channel_pkg.sv | 9 +
 rtl/pwm_if.sv | 27 ++
 rtl/pwm_channel_tick_divider.sv | 29 ++
 rtl/pwm_channel.sv | 64 ++++++
 tb/tb_pwm_channel.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_channel_pkg.sv
// Shared helpers for the PWM channel and its tick divider.
// Sizes prescaler counters so a divide-by-1 still gets one bit.
package pwm_channel_pkg;

  function automatic int cnt_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Control/status bundle between the level source and one PWM channel.
// master drives enable/level, slave returns the PWM state.
interface pwm_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] level;
  logic             out;
  logic             period_start;
  logic [WIDTH-1:0] duty_active;

  modport master (
    output enable,
    output level,
    input  out,
    input  period_start,
    input  duty_active
  );

  modport slave (
    input  enable,
    input  level,
    output out,
    output period_start,
    output duty_active
  );
endinterface

// File: rtl/pwm_channel_tick_divider.sv
// Divide-by-PRESCALE tick generator; clear parks it at the start.
// Also reused by the debounce stage.
module tick_divider
  import pwm_channel_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = cnt_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt <= '0;
    end else if (pre_cnt == LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == LAST);
endmodule

// File: rtl/pwm_channel.sv
// One LED colour channel: free-running period counter, shadowed
// duty word and a registered compare output.
module pwm_channel
  import pwm_channel_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int INVERT   = 0
) (
  input  logic clk,
  input  logic reset,
  pwm_if.slave bus
);
  localparam logic [WIDTH-1:0] LAST = '1;
  localparam logic INV = (INVERT != 0);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] duty;
  logic             out_q;
  logic             ps_q;
  logic             tick;
  logic             clear;
  logic             wrap;

  assign clear = ~bus.enable;
  assign wrap  = tick && (count == LAST);

  tick_divider #(
    .PRESCALE(PRESCALE)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // Duty only swaps at the period wrap so a pulse is never cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      duty  <= '0;
      out_q <= INV;
      ps_q  <= 1'b0;
    end else if (!bus.enable) begin
      count <= '0;
      duty  <= bus.level;
      out_q <= INV;
      ps_q  <= 1'b0;
    end else begin
      if (tick) begin
        count <= count + 1'b1;
      end
      if (wrap) begin
        duty <= bus.level;
      end
      ps_q  <= wrap;
      out_q <= (count < duty) ^ INV;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = ps_q;
  assign bus.duty_active  = duty;
endmodule

// File: tb/tb_pwm_channel.sv
// Bench for pwm_channel: three instances (plain, prescaled, inverted)
// against a period/phase arithmetic reference model.
module tb_pwm_channel;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en;
  logic [7:0] lev[3];

  pwm_if #(.WIDTH(8)) ifa ();
  pwm_if #(.WIDTH(8)) ifb ();
  pwm_if #(.WIDTH(8)) ifc ();

  assign ifa.enable = en;
  assign ifb.enable = en;
  assign ifc.enable = en;
  assign ifa.level  = lev[0];
  assign ifb.level  = lev[1];
  assign ifc.level  = lev[2];

  pwm_channel #(.WIDTH(8), .PRESCALE(1), .INVERT(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  pwm_channel #(.WIDTH(8), .PRESCALE(4), .INVERT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );
  pwm_channel #(.WIDTH(8), .PRESCALE(1), .INVERT(1)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  logic       o_out[3];
  logic       o_ps[3];
  logic [7:0] o_duty[3];

  assign o_out[0]  = ifa.out;
  assign o_out[1]  = ifb.out;
  assign o_out[2]  = ifc.out;
  assign o_ps[0]   = ifa.period_start;
  assign o_ps[1]   = ifb.period_start;
  assign o_ps[2]   = ifc.period_start;
  assign o_duty[0] = ifa.duty_active;
  assign o_duty[1] = ifb.duty_active;
  assign o_duty[2] = ifc.duty_active;

  int vectors = 0;
  int miscompares = 0;

  // Model state: t = enabled clocks since (re)start, md = duty in force.
  int         t[3];
  logic [7:0] md[3];
  logic       m_out[3];
  logic       m_ps[3];

  function automatic int pr(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic logic inv(input int i);
    return (i == 2);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int len;
      int ph;
      int cnt;
      len = pr(i) * 256;
      if (reset) begin
        t[i] = 0;
        md[i] = 8'd0;
        m_out[i] = inv(i);
        m_ps[i] = 1'b0;
      end else if (!en) begin
        t[i] = 0;
        md[i] = lev[i];
        m_out[i] = inv(i);
        m_ps[i] = 1'b0;
      end else begin
        ph = t[i] % len;
        cnt = ph / pr(i);
        m_out[i] = (cnt < int'(md[i])) ^ inv(i);
        m_ps[i] = (ph == len - 1);
        if (m_ps[i]) md[i] = lev[i];
        t[i] = t[i] + 1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      assert (o_out[i] === m_out[i]) else begin
        miscompares++;
        $error("FAIL out[%0d] t=%0d got %b want %b",
               i, t[i], o_out[i], m_out[i]);
      end
      vectors++;
      assert (o_ps[i] === m_ps[i]) else begin
        miscompares++;
        $error("FAIL period_start[%0d] t=%0d got %b want %b",
               i, t[i], o_ps[i], m_ps[i]);
      end
      vectors++;
      assert (o_duty[i] === md[i]) else begin
        miscompares++;
        $error("FAIL duty_active[%0d] t=%0d got %0d want %0d",
               i, t[i], o_duty[i], md[i]);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic chk(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  int hi_a, ps_a, lo_c, hi_b, ps_b, lo_c2;
  bit found;
  int want_hi[5] = '{64, 64, 200, 0, 255};

  initial begin
    reset = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) lev[i] = 8'h80;
    @(posedge clk);
    #1;
    repeat (3) step();

    reset = 1'b0;
    lev[0] = 8'd64;
    lev[1] = 8'd2;
    lev[2] = 8'd100;
    step();
    en = 1'b1;

    hi_b = 0;
    ps_b = 0;
    for (int p = 0; p < 5; p++) begin
      hi_a = 0;
      ps_a = 0;
      lo_c = 0;
      for (int s = 0; s < 256; s++) begin
        if (p == 1 && s == 100) lev[0] = 8'd200;
        if (p == 2 && s == 0) lev[0] = 8'd0;
        if (p == 3 && s == 10) lev[0] = 8'd255;
        step();
        hi_a += int'(o_out[0]);
        ps_a += int'(o_ps[0]);
        lo_c += int'(!o_out[2]);
        hi_b += int'(o_out[1]);
        ps_b += int'(o_ps[1]);
      end
      chk($sformatf("a_high_p%0d", p), hi_a, want_hi[p]);
      chk($sformatf("a_pstart_p%0d", p), ps_a, 1);
      chk($sformatf("c_low_p%0d", p), lo_c, 100);
      if (p == 3) begin
        chk("b_high_1024", hi_b, 8);
        chk("b_pstart_1024", ps_b, 1);
      end
    end

    for (int s = 0; s < 3000; s++) begin
      if ($urandom_range(0, 49) == 0)
        lev[$urandom_range(0, 2)] = 8'($urandom);
      if (!en) en = ($urandom_range(0, 7) == 0);
      else en = ($urandom_range(0, 499) != 0);
      reset = ($urandom_range(0, 799) == 0);
      step();
    end

    reset = 1'b0;
    en = 1'b0;
    lev[2] = 8'd100;
    step();
    en = 1'b1;
    found = 1'b0;
    for (int s = 0; s < 600 && !found; s++) begin
      step();
      if (o_out[2] == 1'b0 && s > 10) found = 1'b1;
    end
    chk("c_pulse_seen", int'(found), 1);
    reset = 1'b1;
    step();
    chk("c_reset_idle", int'(o_out[2]), 1);
    reset = 1'b0;
    repeat (50) step();
    en = 1'b0;
    repeat (5) step();
    chk("c_disable_idle", int'(o_out[2]), 1);
    lev[2] = 8'd30;
    step();
    en = 1'b1;
    lo_c2 = 0;
    for (int s = 0; s < 256; s++) begin
      step();
      lo_c2 += int'(!o_out[2]);
    end
    chk("c_reenable_low", lo_c2, 30);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
